// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Arbitrates two requesters (A, B) onto a single register-file write port.
//   Grants are combinational and round-robin under contention. The selected
//   request is driven onto WriteReg/WriteData/RegWrite one cycle after it is
//   accepted.
//
// Configuration macro:
//   REGWRITE_ZERO_FILTER_EN - when defined, requests to register 0 are accepted
//                             (Ready, LastGrant update) but never raise RegWrite.
//
// Ports:
//   clock, reset_n            - clock (rising edge), async active-low reset
//   A_Valid/A_Reg/A_Data      - requester A write request
//   A_Ready                   - requester A accepted this cycle
//   B_Valid/B_Reg/B_Data      - requester B write request
//   B_Ready                   - requester B accepted this cycle
//   WriteReg/WriteData        - registered register-file write address / data
//   RegWrite                  - registered register-file write enable
//   LastGrant                 - 0: A granted most recently, 1: B
module regfile_write_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  A_Valid,
   input  logic [ADDR_WIDTH-1:0] A_Reg,
   input  logic [DATA_WIDTH-1:0] A_Data,
   output logic                  A_Ready,
   input  logic                  B_Valid,
   input  logic [ADDR_WIDTH-1:0] B_Reg,
   input  logic [DATA_WIDTH-1:0] B_Data,
   output logic                  B_Ready,
   output logic [ADDR_WIDTH-1:0] WriteReg,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  RegWrite,
   output logic                  LastGrant
);

   logic                  last_grant_q, last_grant_d;
   logic                  reg_write_q, reg_write_d;
   logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
   logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

   logic                  a_ready, b_ready, accept, commit;
   logic [ADDR_WIDTH-1:0] sel_reg;
   logic [DATA_WIDTH-1:0] sel_data;

   // Grant: a lone requester always wins; on contention the requester that
   // did not win last time wins. Both readies are held low while in reset.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (reset_n) begin
         if (A_Valid && (!B_Valid || last_grant_q)) begin
            a_ready = 1'b1;
         end else if (B_Valid) begin
            b_ready = 1'b1;
         end
      end
   end

   assign accept   = a_ready | b_ready;
   assign sel_reg  = b_ready ? B_Reg  : A_Reg;
   assign sel_data = b_ready ? B_Data : A_Data;

`ifdef REGWRITE_ZERO_FILTER_EN
   // Register 0 is hard-wired: accept the request but drop the write.
   assign commit = accept && (sel_reg != '0);
`else
   assign commit = accept;
`endif

   always_comb begin
      last_grant_d = last_grant_q;
      reg_write_d  = commit;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (accept) begin
         last_grant_d = b_ready;
      end
      if (commit) begin
         write_reg_d  = sel_reg;
         write_data_d = sel_data;
      end
   end

   // LastGrant resets to B so that A wins the first contention.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= 1'b1;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign A_Ready   = a_ready;
   assign B_Ready   = b_ready;
   assign RegWrite  = reg_write_q;
   assign WriteReg  = write_reg_q;
   assign WriteData = write_data_q;
   assign LastGrant = last_grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: table of request vectors with expected
// grants and LastGrant; the expected write-port value of each cycle is queued
// when the stimulus is applied and popped after the following clock edge.
module tb_regfile_write_arbiter;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        A_Valid = 1'b0;
   logic [4:0]  A_Reg = '0;
   logic [31:0] A_Data = '0;
   logic        A_Ready;
   logic        B_Valid = 1'b0;
   logic [4:0]  B_Reg = '0;
   logic [31:0] B_Data = '0;
   logic        B_Ready;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic        LastGrant;

   regfile_write_arbiter #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(5)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .A_Valid  (A_Valid),
      .A_Reg    (A_Reg),
      .A_Data   (A_Data),
      .A_Ready  (A_Ready),
      .B_Valid  (B_Valid),
      .B_Reg    (B_Reg),
      .B_Data   (B_Data),
      .B_Ready  (B_Ready),
      .WriteReg (WriteReg),
      .WriteData(WriteData),
      .RegWrite (RegWrite),
      .LastGrant(LastGrant)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        rst;   // pulse reset before this vector
      logic        av;
      logic [4:0]  ar;
      logic [31:0] ad;
      logic        bv;
      logic [4:0]  br;
      logic [31:0] bd;
      logic        ea;    // expected A_Ready
      logic        eb;    // expected B_Ready
      logic        elg;   // expected LastGrant after the edge
   } vec_t;

   typedef struct {
      logic        wr;
      logic [4:0]  wreg;
      logic [31:0] wdata;
   } exp_t;

   vec_t        vecs[$];
   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [4:0]  hold_reg = '0;
   logic [31:0] hold_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic rst, input logic av, input logic [4:0] ar,
                      input logic [31:0] ad, input logic bv, input logic [4:0] br,
                      input logic [31:0] bd, input logic ea, input logic eb,
                      input logic elg);
      vecs.push_back('{rst, av, ar, ad, bv, br, bd, ea, eb, elg});
   endtask

   task automatic idle_inputs();
      A_Valid = 1'b0; A_Reg = '0; A_Data = '0;
      B_Valid = 1'b0; B_Reg = '0; B_Data = '0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      A_Valid = 1'b1; A_Reg = 5'd9; A_Data = 32'h99;
      B_Valid = 1'b1; B_Reg = 5'd8; B_Data = 32'h88;
      #1;
      chk("rst_A_Ready", {31'b0, A_Ready}, 32'd0);
      chk("rst_B_Ready", {31'b0, B_Ready}, 32'd0);
      chk("rst_RegWrite", {31'b0, RegWrite}, 32'd0);
      chk("rst_WriteReg", {27'b0, WriteReg}, 32'd0);
      chk("rst_WriteData", WriteData, 32'd0);
      chk("rst_LastGrant", {31'b0, LastGrant}, 32'd1);
      @(negedge clock);
      reset_n = 1'b1;
      idle_inputs();
      sb.delete();
      hold_reg = '0;
      hold_data = '0;
   endtask

   task automatic step(input vec_t v);
      logic        acc;
      logic        wr;
      logic [4:0]  r;
      logic [31:0] d;
      exp_t        e;
      if (v.rst) do_reset();
      @(negedge clock);
      A_Valid = v.av; A_Reg = v.ar; A_Data = v.ad;
      B_Valid = v.bv; B_Reg = v.br; B_Data = v.bd;
      #1;
      chk("A_Ready", {31'b0, A_Ready}, {31'b0, v.ea});
      chk("B_Ready", {31'b0, B_Ready}, {31'b0, v.eb});
      acc = v.ea | v.eb;
      r = v.eb ? v.br : v.ar;
      d = v.eb ? v.bd : v.ad;
      wr = acc;
`ifdef REGWRITE_ZERO_FILTER_EN
      if (r == 5'd0) wr = 1'b0;
`endif
      if (wr) begin
         hold_reg = r;
         hold_data = d;
      end
      sb.push_back('{wr, hold_reg, hold_data});
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard: got empty queue, expected one entry");
      end else begin
         e = sb.pop_front();
         chk("RegWrite", {31'b0, RegWrite}, {31'b0, e.wr});
         chk("WriteReg", {27'b0, WriteReg}, {27'b0, e.wreg});
         chk("WriteData", WriteData, e.wdata);
      end
      chk("LastGrant", {31'b0, LastGrant}, {31'b0, v.elg});
   endtask

   initial begin
      // Single A write, then idle: one-cycle pulse, outputs hold.
      add(1, 1, 5'd3, 32'd10, 0, 5'd0, 32'd0, 1, 0, 0);
      add(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0);
      // Continuous contention after reset: A, B, A, B with no bubble.
      add(1, 1, 5'd1, 32'd11, 1, 5'd2, 32'd22, 1, 0, 0);
      add(0, 1, 5'd1, 32'd11, 1, 5'd2, 32'd22, 0, 1, 1);
      add(0, 1, 5'd1, 32'd11, 1, 5'd2, 32'd22, 1, 0, 0);
      add(0, 1, 5'd1, 32'd11, 1, 5'd2, 32'd22, 0, 1, 1);
      add(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 1);
      // Same register from both: A's 7 then B's 9, 9 remains.
      add(1, 1, 5'd5, 32'd7, 1, 5'd5, 32'd9, 1, 0, 0);
      add(0, 0, 5'd5, 32'd7, 1, 5'd5, 32'd9, 0, 1, 1);
      add(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 1);
      // B alone three times, then contention goes to A, then B.
      add(1, 0, 5'd0, 32'd0, 1, 5'd4, 32'd44, 0, 1, 1);
      add(0, 0, 5'd0, 32'd0, 1, 5'd4, 32'd44, 0, 1, 1);
      add(0, 0, 5'd0, 32'd0, 1, 5'd4, 32'd44, 0, 1, 1);
      add(0, 1, 5'd6, 32'd66, 1, 5'd4, 32'd45, 1, 0, 0);
      add(0, 0, 5'd0, 32'd0, 1, 5'd4, 32'd45, 0, 1, 1);
      add(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 1);
      // Register 0 writes (filtered or not depending on build).
      add(0, 1, 5'd0, 32'd10, 0, 5'd0, 32'd0, 1, 0, 0);
      add(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0);
      add(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'd5, 0, 1, 1);
      add(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 1);
      // Accept that precedes the mid-stream reset below.
      add(0, 1, 5'd3, 32'd10, 0, 5'd0, 32'd0, 1, 0, 0);

      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      foreach (vecs[i]) step(vecs[i]);

      // Mid-stream reset in the cycle A is being accepted.
      @(negedge clock);
      A_Valid = 1'b1; A_Reg = 5'd7; A_Data = 32'd77;
      #1;
      chk("mid_A_Ready", {31'b0, A_Ready}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_RegWrite", {31'b0, RegWrite}, 32'd0);
      chk("mid_WriteReg", {27'b0, WriteReg}, 32'd0);
      chk("mid_WriteData", WriteData, 32'd0);
      chk("mid_LastGrant", {31'b0, LastGrant}, 32'd1);
      chk("mid_A_Ready_rst", {31'b0, A_Ready}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      idle_inputs();
      sb.delete();
      hold_reg = '0;
      hold_data = '0;
      step('{0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 1});
      step('{0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 1});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, register index width (32 registers).
REQ-003 The block SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have ports A_Valid  input  1; A_Reg  input  ADDR_WIDTH; A_Data  input  DATA_WIDTH: requester A write request.
REQ-006 The block SHALL have port A_Ready  output  1  requester A request accepted this cycle.
REQ-007 The block SHALL have ports B_Valid  input  1; B_Reg  input  ADDR_WIDTH; B_Data  input  DATA_WIDTH: requester B write request.
REQ-008 The block SHALL have port B_Ready  output  1  requester B request accepted this cycle.
REQ-009 The block SHALL have ports WriteReg  output  ADDR_WIDTH; WriteData  output  DATA_WIDTH; RegWrite  output  1: registered drive of the register file write port.
REQ-010 The block SHALL have port LastGrant  output  1  0 = A granted most recently, 1 = B.

Function
REQ-011 Grant decision SHALL be combinational per cycle; A_Ready/B_Ready SHALL be one-hot or both 0, never both 1.
REQ-012 Only A_Valid=1: A_Ready=1. Only B_Valid=1: B_Ready=1. Neither: both 0.
REQ-013 Both valid: grant SHALL go to the requester not equal to LastGrant (round-robin); max wait for either requester = 1 cycle.
REQ-014 LastGrant SHALL update on every accepted request to the granted requester; otherwise hold.
REQ-015 Accepted request SHALL appear on WriteReg/WriteData with RegWrite=1 the following cycle (latency 1), RegWrite high exactly one cycle per accept.
REQ-016 Back-to-back accepts SHALL produce RegWrite=1 on consecutive cycles with no bubble.
REQ-017 No accept: RegWrite SHALL be 0 next cycle; WriteReg/WriteData SHALL hold last values.
REQ-018 Both valid with equal Reg: round-robin unchanged; loser's write committed one cycle after winner's, so loser's data is the final value.
REQ-019 Ready SHALL not depend on Reg/Data values (except REQ-026 filtering, which still accepts).
REQ-020 Requester holding Valid without Ready SHALL keep Reg/Data stable; block SHALL not latch unaccepted requests.

Reset
REQ-021 reset_n=0 SHALL immediately force RegWrite=0, WriteReg=0, WriteData=0, LastGrant=1 (so A wins first contention).
REQ-022 During reset A_Ready and B_Ready SHALL be 0.
REQ-023 Reset asserted mid-stream SHALL discard any accept of that cycle; no RegWrite pulse after reset release without a new accept.
REQ-024 First rising edge after reset_n deasserts SHALL arbitrate normally.

Configuration
REQ-025 Macro REGWRITE_ZERO_FILTER_EN SHALL select register-0 write filtering.
REQ-026 Defined: request to Reg=0 is accepted (Ready=1, LastGrant updates) but RegWrite stays 0 next cycle; WriteReg/WriteData hold.
REQ-027 Undefined: Reg=0 requests treated as any other register (RegWrite=1, WriteReg=0).

Verification
REQ-028 Reset then A_Valid=1, A_Reg=3, A_Data=10 one cycle -> A_Ready=1; next cycle RegWrite=1, WriteReg=3, WriteData=10; following cycle RegWrite=0.
REQ-029 A and B valid continuously for 4 cycles (A_Reg=1/Data=11, B_Reg=2/Data=22) -> grants A,B,A,B; RegWrite=1 four consecutive cycles, outputs alternating.
REQ-030 Both valid, A_Reg=B_Reg=5, A_Data=7, B_Data=9, after reset -> A first, B next; WriteData sequence 7 then 9.
REQ-031 A_Valid=1, A_Reg=0, A_Data=10: with REGWRITE_ZERO_FILTER_EN -> A_Ready=1, RegWrite stays 0; without -> RegWrite=1, WriteReg=0, WriteData=10.
REQ-032 reset_n driven 0 in cycle where A accepted -> RegWrite=0, WriteReg=0, WriteData=0 immediately, no pulse after release.
REQ-033 Only B valid 3 cycles then both valid -> B,B,B accepted, then A granted (LastGrant=1).
